// File: rtl/i2c_slave.sv
`default_nettype none
// ============================================================================
// Module      : i2c_slave
// Description : I2C target with oversampled SCL/SDA, START/STOP detection,
//               7-bit address match, byte write receive and byte read send.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_slave #(
    parameter logic [6:0] SLV_ADDR    = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy
);

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_ADDR      = 3'd1;
    localparam logic [2:0] c_ST_ADDR_ACK  = 3'd2;
    localparam logic [2:0] c_ST_WR_DATA   = 3'd3;
    localparam logic [2:0] c_ST_WR_ACK    = 3'd4;
    localparam logic [2:0] c_ST_RD_DATA   = 3'd5;
    localparam logic [2:0] c_ST_RD_ACK    = 3'd6;
    localparam logic [2:0] c_ST_WAIT_STOP = 3'd7;

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_hist;
    logic                   r_sda_hist;

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic [3:0] r_cnt;
    logic [6:0] r_rx_shift;
    logic [7:0] r_tx_shift;
    logic       r_rw;
    logic       r_sda_low;
    logic       r_busy;
    logic       r_tx_req;
    logic       r_rx_valid;
    logic [7:0] r_rx_data;

    logic       w_scl;
    logic       w_sda;
    logic       w_scl_rise;
    logic       w_scl_fall;
    logic       w_start;
    logic       w_stop;
    logic       w_byte_end;
    logic       w_addr_hit;

    logic       w_tx_load;
    logic       w_rx_load;
    logic       w_shift_in;
    logic       w_rw_load;
    logic       w_tx_step;
    logic       w_sda_low_nxt;
    logic [3:0] w_cnt_nxt;
    logic       w_busy_nxt;

    // Synchronizers reset to the idle-bus level so reset release never looks like an edge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_hist <= 1'b1;
            r_sda_hist <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda};
            r_scl_hist <= r_scl_sync[SYNC_STAGES-1];
            r_sda_hist <= r_sda_sync[SYNC_STAGES-1];
        end
    end

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise = w_scl & ~r_scl_hist;
    assign w_scl_fall = ~w_scl & r_scl_hist;
    assign w_start    = w_scl & r_scl_hist & r_sda_hist & ~w_sda;
    assign w_stop     = w_scl & r_scl_hist & ~r_sda_hist & w_sda;
    assign w_byte_end = (r_cnt == 4'd7);
    // General call (address 0) is deliberately never acknowledged
    assign w_addr_hit = (r_rx_shift == SLV_ADDR) && (r_rx_shift != 7'd0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_start) begin
            w_state_nxt = c_ST_ADDR;
        end else if (w_stop) begin
            w_state_nxt = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_ADDR: begin
                    if (w_scl_rise && w_byte_end)
                        w_state_nxt = w_addr_hit ? c_ST_ADDR_ACK : c_ST_WAIT_STOP;
                end
                c_ST_ADDR_ACK: begin
                    if (w_scl_fall && r_sda_low)
                        w_state_nxt = r_rw ? c_ST_RD_DATA : c_ST_WR_DATA;
                end
                c_ST_WR_DATA: begin
                    if (w_scl_rise && w_byte_end)
                        w_state_nxt = c_ST_WR_ACK;
                end
                c_ST_WR_ACK: begin
                    if (w_scl_fall && r_sda_low)
                        w_state_nxt = c_ST_WR_DATA;
                end
                c_ST_RD_DATA: begin
                    if (w_scl_fall && (r_cnt == 4'd8))
                        w_state_nxt = c_ST_RD_ACK;
                end
                c_ST_RD_ACK: begin
                    // Entered on a fall, so the next fall seen here follows the ACK rise
                    if (w_scl_rise && w_sda)
                        w_state_nxt = c_ST_WAIT_STOP;
                    else if (w_scl_fall)
                        w_state_nxt = c_ST_RD_DATA;
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_comb begin
        w_tx_load     = 1'b0;
        w_rx_load     = 1'b0;
        w_shift_in    = 1'b0;
        w_rw_load     = 1'b0;
        w_tx_step     = 1'b0;
        w_sda_low_nxt = r_sda_low;
        w_cnt_nxt     = r_cnt;
        w_busy_nxt    = r_busy;
        if (w_start || w_stop) begin
            w_sda_low_nxt = 1'b0;
            w_cnt_nxt     = 4'd0;
            w_busy_nxt    = 1'b0;
        end else begin
            case (r_state)
                c_ST_ADDR: begin
                    w_sda_low_nxt = 1'b0;
                    if (w_scl_rise) begin
                        w_shift_in = 1'b1;
                        w_cnt_nxt  = w_byte_end ? 4'd0 : r_cnt + 4'd1;
                        if (w_byte_end) begin
                            w_rw_load = 1'b1;
                            if (w_addr_hit) begin
                                w_busy_nxt = 1'b1;
                                w_tx_load  = w_sda;
                            end
                        end
                    end
                end
                c_ST_ADDR_ACK, c_ST_WR_ACK: begin
                    // r_sda_low doubles as "ACK already on the bus" for this bit
                    if (w_scl_fall) begin
                        if (!r_sda_low) begin
                            w_sda_low_nxt = 1'b1;
                        end else if ((r_state == c_ST_ADDR_ACK) && r_rw) begin
                            w_sda_low_nxt = ~r_tx_shift[7];
                            w_tx_step     = 1'b1;
                        end else begin
                            w_sda_low_nxt = 1'b0;
                        end
                    end
                end
                c_ST_WR_DATA: begin
                    w_sda_low_nxt = 1'b0;
                    if (w_scl_rise) begin
                        w_shift_in = 1'b1;
                        w_cnt_nxt  = w_byte_end ? 4'd0 : r_cnt + 4'd1;
                        w_rx_load  = w_byte_end;
                    end
                end
                c_ST_RD_DATA: begin
                    if (w_scl_rise) begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end else if (w_scl_fall) begin
                        if (r_cnt == 4'd8) begin
                            w_sda_low_nxt = 1'b0;
                            w_cnt_nxt     = 4'd0;
                        end else begin
                            w_sda_low_nxt = ~r_tx_shift[7];
                            w_tx_step     = 1'b1;
                        end
                    end
                end
                c_ST_RD_ACK: begin
                    if (w_scl_rise) begin
                        if (w_sda) w_busy_nxt = 1'b0;
                        else       w_tx_load  = 1'b1;
                    end else if (w_scl_fall) begin
                        w_sda_low_nxt = ~r_tx_shift[7];
                        w_tx_step     = 1'b1;
                    end
                end
                default: w_sda_low_nxt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt      <= 4'd0;
            r_rx_shift <= 7'd0;
            r_tx_shift <= 8'd0;
            r_rw       <= 1'b0;
            r_sda_low  <= 1'b0;
            r_busy     <= 1'b0;
            r_tx_req   <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_data  <= 8'h00;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_sda_low  <= w_sda_low_nxt;
            r_busy     <= w_busy_nxt;
            r_tx_req   <= w_tx_load;
            r_rx_valid <= w_rx_load;
            if (w_rx_load)  r_rx_data  <= {r_rx_shift, w_sda};
            if (w_shift_in) r_rx_shift <= {r_rx_shift[5:0], w_sda};
            if (w_rw_load)  r_rw       <= w_sda;
            if (w_tx_load)
                r_tx_shift <= tx_data;
            else if (w_tx_step)
                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
        end
    end

    assign sda      = r_sda_low ? 1'b0 : 1'bz;
    assign tx_req   = r_tx_req;
    assign rx_valid = r_rx_valid;
    assign rx_data  = r_rx_data;
    assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_slave
// Description : Bus-level bench for i2c_slave with a bit-banged master.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_slave;

    logic       clk       = 1'b0;
    logic       rstn      = 1'b0;
    logic       scl       = 1'b1;
    logic       m_sda_low = 1'b0;
    logic [7:0] tx_data   = 8'h00;
    wire        sda;
    logic       tx_req;
    logic       rx_valid;
    logic       busy;
    logic [7:0] rx_data;

    pullup (sda);
    assign sda = m_sda_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_slave #(.SLV_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .scl      (scl),
        .sda      (sda),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy)
    );

    int errors  = 0;
    int checks  = 0;
    int rxv_cnt = 0;
    int txr_cnt = 0;
    bit both_hi = 1'b0;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) rxv_cnt++;
        if (tx_req === 1'b1) txr_cnt++;
        if ((rx_valid === 1'b1) && (tx_req === 1'b1)) both_hi = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic q();
        repeat (8) @(negedge clk);
    endtask

    task automatic start_cond();
        m_sda_low = 1'b0; q();
        scl = 1'b1;       q();
        m_sda_low = 1'b1; q();
        scl = 1'b0;       q();
    endtask

    task automatic stop_cond();
        m_sda_low = 1'b1; q();
        scl = 1'b1;       q();
        m_sda_low = 1'b0; q();
    endtask

    task automatic write_bit(input logic b);
        m_sda_low = ~b; q();
        scl = 1'b1;     q();
        scl = 1'b0;     q();
    endtask

    task automatic read_bit(output logic b);
        m_sda_low = 1'b0; q();
        scl = 1'b1;       q();
        b = sda;
        scl = 1'b0;       q();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(r);
        ack = ~r;
    endtask

    task automatic read_byte(output logic [7:0] b, input logic give_ack);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            read_bit(r);
            b[i] = r;
        end
        write_bit(~give_ack);
    endtask

    initial begin
        logic       ack;
        logic [7:0] got;
        logic [7:0] d;
        logic [7:0] exp_b;
        logic [7:0] exp_rx;
        logic [6:0] a;
        logic       rw;
        logic       hit;
        int         n;
        int         rx0;
        int         tx0;

        exp_rx = 8'h00;
        repeat (4) @(negedge clk);
        check("reset_sda", sda, 1'b1);
        check("reset_tx_req", tx_req, 1'b0);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_valid", rx_valid, 1'b0);
        check("reset_busy", busy, 1'b0);
        rstn = 1'b1;
        q();

        // Write 0x5A to our address
        rx0 = rxv_cnt;
        start_cond();
        send_byte({7'h50, 1'b0}, ack);
        check("t1_addr_ack", ack, 1'b1);
        check("t1_busy", busy, 1'b1);
        send_byte(8'h5A, ack);
        check("t1_data_ack", ack, 1'b1);
        stop_cond();
        check("t1_rx_data", rx_data, 8'h5A);
        check("t1_rx_pulses", rxv_cnt - rx0, 1);
        check("t1_busy_after_stop", busy, 1'b0);
        exp_rx = 8'h5A;

        // Wrong address is ignored
        rx0 = rxv_cnt;
        start_cond();
        send_byte({7'h51, 1'b0}, ack);
        check("t2_addr_nack", ack, 1'b0);
        check("t2_busy", busy, 1'b0);
        send_byte(8'hFF, ack);
        check("t2_data_nack", ack, 1'b0);
        stop_cond();
        check("t2_rx_pulses", rxv_cnt - rx0, 0);
        check("t2_rx_data", rx_data, exp_rx);

        // Read two bytes, ACK then NACK
        tx0 = txr_cnt;
        tx_data = 8'hA5;
        start_cond();
        send_byte({7'h50, 1'b1}, ack);
        check("t3_addr_ack", ack, 1'b1);
        tx_data = 8'h3C;
        read_byte(got, 1'b1);
        check("t3_byte0", got, 8'hA5);
        tx_data = 8'h77;
        read_byte(got, 1'b0);
        check("t3_byte1", got, 8'h3C);
        q();
        check("t3_sda_released", sda, 1'b1);
        check("t3_busy_after_nack", busy, 1'b0);
        stop_cond();
        check("t3_tx_pulses", txr_cnt - tx0, 2);

        // Write then repeated START into a read
        start_cond();
        send_byte({7'h50, 1'b0}, ack);
        check("t4_waddr_ack", ack, 1'b1);
        send_byte(8'h11, ack);
        check("t4_wdata_ack", ack, 1'b1);
        start_cond();
        check("t4_busy_rstart", busy, 1'b0);
        check("t4_rx_data", rx_data, 8'h11);
        exp_rx = 8'h11;
        d = 8'($urandom);
        tx_data = d;
        send_byte({7'h50, 1'b1}, ack);
        check("t4_raddr_ack", ack, 1'b1);
        check("t4_busy_read", busy, 1'b1);
        read_byte(got, 1'b0);
        check("t4_read_byte", got, d);
        stop_cond();

        // Randomized transactions against a transaction-level model
        for (int t = 0; t < 12; t++) begin
            a   = ($urandom_range(0, 1) == 1) ? 7'h50 : 7'($urandom);
            hit = (a == 7'h50);
            rw  = 1'($urandom_range(0, 1));
            n   = $urandom_range(1, 3);
            rx0 = rxv_cnt;
            tx0 = txr_cnt;
            exp_b = 8'($urandom);
            tx_data = exp_b;
            start_cond();
            send_byte({a, rw}, ack);
            check("rnd_addr_ack", ack, hit);
            check("rnd_busy", busy, hit);
            if (!rw) begin
                if (hit) begin
                    for (int k = 0; k < n; k++) begin
                        d = 8'($urandom);
                        send_byte(d, ack);
                        check("rnd_wdata_ack", ack, 1'b1);
                        exp_rx = d;
                    end
                end else begin
                    send_byte(8'($urandom), ack);
                    check("rnd_wdata_nack", ack, 1'b0);
                end
            end else if (hit) begin
                for (int k = 0; k < n; k++) begin
                    tx_data = 8'($urandom);
                    read_byte(got, (k < n - 1));
                    check("rnd_rdata", got, exp_b);
                    exp_b = tx_data;
                end
            end
            stop_cond();
            check("rnd_rx_pulses", rxv_cnt - rx0, (hit && !rw) ? n : 0);
            check("rnd_tx_pulses", txr_cnt - tx0, (hit && rw) ? n : 0);
            check("rnd_rx_data", rx_data, exp_rx);
            check("rnd_busy_idle", busy, 1'b0);
        end

        // STOP after a partial data byte
        rx0 = rxv_cnt;
        start_cond();
        send_byte({7'h50, 1'b0}, ack);
        check("t5_addr_ack", ack, 1'b1);
        for (int i = 0; i < 4; i++) write_bit(1'($urandom));
        stop_cond();
        check("t5_rx_pulses", rxv_cnt - rx0, 0);
        check("t5_rx_data", rx_data, exp_rx);
        check("t5_busy", busy, 1'b0);

        // Reset while the target is driving a 0 data bit
        tx_data = 8'h00;
        start_cond();
        send_byte({7'h50, 1'b1}, ack);
        check("t6_addr_ack", ack, 1'b1);
        read_bit(got[7]);
        check("t6_bit7", got[7], 1'b0);
        m_sda_low = 1'b0; q();
        scl = 1'b1;
        repeat (4) @(negedge clk);
        check("t6_sda_driven", sda, 1'b0);
        rstn = 1'b0;
        #1;
        check("t6_sda_released", sda, 1'b1);
        check("t6_busy", busy, 1'b0);
        check("t6_rx_data", rx_data, 8'h00);
        check("t6_tx_req", tx_req, 1'b0);
        check("t6_rx_valid", rx_valid, 1'b0);
        exp_rx = 8'h00;
        @(negedge clk);
        rstn = 1'b1;
        scl = 1'b0; q();
        stop_cond();
        d = 8'($urandom);
        start_cond();
        send_byte({7'h50, 1'b0}, ack);
        check("t6_recover_ack", ack, 1'b1);
        send_byte(d, ack);
        check("t6_recover_data_ack", ack, 1'b1);
        stop_cond();
        check("t6_recover_rx", rx_data, d);

        check("rx_tx_exclusive", both_hi, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
